sc_program_loader: RTL and testbench

Boot-time instruction-memory writer for the single-cycle MIPS core. The core only reads instruction memory; this block writes it. It accepts a byte stream over a valid/ready handshake, packs the bytes into big-endian 32-bit words, and writes them to instruction memory at consecutive word addresses. While loading it holds the core in reset with enable low, then releases the core so it fetches from the loaded program.

---
 rtl/sc_loader_pkg.sv | 28 ++
 rtl/sc_byte_packer.sv | 48 ++++
 rtl/sc_program_loader.sv | 161 ++++++++++++++++
 tb/tb_sc_program_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Optional feature macro: SC_LOADER_CHECKSUM_EN (adds the CHECK state).
package sc_loader_pkg;

    // Bytes packed into one instruction word.
    localparam int BYTES_PER_WORD = 4;

    // Default placement and size limit of a loaded program.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
    localparam int          DEFAULT_MAX_WORDS = 256;

    // Loader FSM states. S_CHECK is only entered when the checksum trailer is enabled.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } loader_state_t;

    // States in which the loader consumes a stream byte.
    function automatic logic state_takes_byte(input loader_state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/sc_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words. The first byte of a word ends
// up in bits 31:24. word_valid pulses for one cycle after the 4th byte of a word
// is accepted; word_data holds its value until the next completed word.
module sc_byte_packer
    import sc_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_cnt,
    output logic        word_valid,
    output logic [31:0] word_data
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    // Holds the (up to three) earlier bytes of the word being assembled.
    logic [23:0] shreg;

    // Shift in accepted bytes; emit a word on the last byte of each group of four.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg      <= '0;
            byte_cnt   <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                // A restart discards the partial word but leaves the last written word visible.
                shreg    <= '0;
                byte_cnt <= '0;
            end else if (byte_valid) begin
                shreg <= {shreg[15:0], byte_data};
                if (byte_cnt == LAST_BYTE) begin
                    word_valid <= 1'b1;
                    word_data  <= {shreg, byte_data};
                    byte_cnt   <= '0;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/sc_program_loader.sv
// Boot-time instruction-memory writer for the single-cycle MIPS core.
// Stream: length hi, length lo (word count N), then 4*N data bytes MSB first.
// Optional feature macro: SC_LOADER_CHECKSUM_EN -- a trailing byte equal to the XOR
// of all previous stream bytes is required; a mismatch aborts the load.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready is combinational from state and start only (never from in_valid);
// bytes presented while in_ready is low are dropped, never buffered.
module sc_program_loader
    import sc_loader_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                 MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                core_reset,
    output logic                core_enable,
    output logic                done,
    output logic                error,
    output loader_state_t       state_dbg
);

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

`ifdef SC_LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = S_CHECK;
`else
    localparam loader_state_t AFTER_DATA = S_DONE;
`endif

    loader_state_t state;
    loader_state_t state_nxt;

    logic [7:0]        len_hi;
    logic [15:0]       len;
    logic [15:0]       word_idx;
    logic [15:0]       len_word;
    logic [ADDR_W-1:0] word_off;
    logic              hs;
    logic              data_hs;
    logic              word_end;
    logic [1:0]        byte_cnt;

`ifdef SC_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    assign in_ready  = state_takes_byte(state) && !start;
    assign hs        = in_valid && in_ready;
    assign data_hs   = hs && (state == S_DATA);
    assign word_end  = data_hs && (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign len_word  = {len_hi, in_data};
    assign word_off  = ADDR_W'({word_idx, 2'b00});
    assign state_dbg = state;

    sc_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start),
        .byte_valid (data_hs),
        .byte_data  (in_data),
        .byte_cnt   (byte_cnt),
        .word_valid (imem_we),
        .word_data  (imem_wdata)
    );

    // Next-state decision; start overrides everything, otherwise advance on a handshake.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_LEN_HI;
        end else if (hs) begin
            case (state)
                S_LEN_HI: state_nxt = S_LEN_LO;
                S_LEN_LO: begin
                    if ({1'b0, len_word} > MAX_LEN) begin
                        state_nxt = S_ERROR;
                    end else if (len_word == 16'd0) begin
                        state_nxt = AFTER_DATA;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    if (word_end && (word_idx + 16'd1 == len)) begin
                        state_nxt = AFTER_DATA;
                    end
                end
`ifdef SC_LOADER_CHECKSUM_EN
                S_CHECK:  state_nxt = (in_data == csum) ? S_DONE : S_ERROR;
`endif
                default:  state_nxt = state;
            endcase
        end
    end

    // State register plus core control / status outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            core_reset  <= 1'b1;
            core_enable <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_nxt;
            core_reset  <= (state_nxt != S_DONE);
            core_enable <= (state_nxt == S_DONE);
            done        <= (state_nxt == S_DONE);
            error       <= (state_nxt == S_ERROR);
        end
    end

    // Length capture, word index and write address; the address is set together
    // with the packer's word strobe so both appear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi    <= '0;
            len       <= '0;
            word_idx  <= '0;
            imem_addr <= BASE_ADDR;
        end else if (start) begin
            len      <= '0;
            word_idx <= '0;
        end else if (hs) begin
            if (state == S_LEN_HI) begin
                len_hi <= in_data;
            end
            if (state == S_LEN_LO) begin
                len <= len_word;
            end
            if (word_end) begin
                imem_addr <= BASE_ADDR + word_off;
                word_idx  <= word_idx + 16'd1;
            end
        end
    end

`ifdef SC_LOADER_CHECKSUM_EN
    // Running XOR of every byte from length-high through the last data byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (start) begin
            csum <= '0;
        end else if (hs && (state != S_CHECK)) begin
            csum <= csum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_sc_program_loader.sv
// Self-checking bench for sc_program_loader: random streams, a stream-level
// reference model, and a write scoreboard drained by an independent monitor.
module tb_sc_program_loader;
  import sc_loader_pkg::*;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_0400;
  localparam int          MAXW   = 256;
`ifdef SC_LOADER_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic              clk;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              core_enable;
  logic              done;
  logic              error;
  loader_state_t     state_dbg;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stream[$];
  bit          exp_done;
  bit          exp_error;
  int          n_consumed;
  bit          bp;

  sc_program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .core_enable(core_enable), .done(done), .error(error),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every write strobe pops one expected {addr, data}
  always @(negedge clk) begin
    if (reset === 1'b0 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h@%0h required=none", imem_wdata, imem_addr);
      end else begin
        check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
      end
    end
  end

  // reference model: parse the stream by its format rules; only words whose four
  // bytes are among the first sent_limit stream bytes are expected to be written
  task automatic predict(input int sent_limit);
    int n;
    logic [7:0] x;
    n = int'({stream[0], stream[1]});
    if (n > MAXW) begin
      exp_done = 1'b0;
      exp_error = 1'b1;
      n_consumed = 2;
      return;
    end
    n_consumed = 2 + 4 * n + CSUM;
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x = x ^ stream[i];
    for (int k = 0; k < n; k++) begin
      if (2 + 4 * k + 3 < sent_limit)
        exp_q.push_back({BASE + 32'(4 * k),
                         stream[2+4*k], stream[3+4*k], stream[4+4*k], stream[5+4*k]});
    end
    if (CSUM != 0) begin
      exp_done = (stream[2 + 4 * n] == x);
      exp_error = !exp_done;
    end else begin
      exp_done = 1'b1;
      exp_error = 1'b0;
    end
  endtask

  task automatic make_stream(input int n, input bit bad);
    logic [7:0] x;
    logic [15:0] nn;
    stream.delete();
    nn = 16'(n);
    stream.push_back(nn[15:8]);
    stream.push_back(nn[7:0]);
    for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom_range(0, 255)));
    x = 8'h00;
    foreach (stream[i]) x = x ^ stream[i];
    if (CSUM != 0) stream.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  // driver: called just after a falling edge; returns at the falling edge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int g;
    bit got;
    g = bp ? $urandom_range(0, 2) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      in_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = b;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      #1;
      if (in_ready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL byte_accept actual=no_ready required=ready");
    end
  endtask

  task automatic pulse_start(input bit with_byte);
    start = 1'b1;
    in_valid = with_byte;
    in_data = 8'($urandom_range(0, 255));
    #1;
    check("ready_low_on_start", in_ready, 1'b0);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    check("loading_holds_core", {done, error, core_reset, core_enable}, 4'b0010);
  endtask

  task automatic offer_ignored(input int cycles);
    repeat (cycles) begin
      in_valid = 1'b1;
      in_data = 8'($urandom_range(0, 255));
      #1;
      check("ready_low_when_finished", in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // full load of the current stream
  task automatic run_load();
    int n;
    predict(1 << 30);
    n = int'({stream[0], stream[1]});
    pulse_start($urandom_range(0, 1) == 1);
    for (int i = 0; i < n_consumed; i++) begin
      send_byte(stream[i]);
      if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3)
        check("we_after_4th_byte", imem_we, 1'b1);
    end
    in_valid = 1'b0;
    check("release_status", {done, error, core_reset, core_enable},
          {exp_done, exp_error, !exp_done, exp_done});
    offer_ignored(3);
    repeat (2) @(negedge clk);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    check("final_hold", {done, error, core_reset, core_enable},
          {exp_done, exp_error, !exp_done, exp_done});
  endtask

  // start arrives after `sent` stream bytes of an in-progress load
  task automatic partial_then_restart(input int sent);
    make_stream(2, 1'b0);
    predict(sent);
    pulse_start(1'b0);
    for (int i = 0; i < sent; i++) send_byte(stream[i]);
    pulse_start(1'b1);
    repeat (2) @(negedge clk);
    check("partial_writes_drained", 64'(exp_q.size()), 64'd0);
    stream.delete();
    stream.push_back(8'h00); stream.push_back(8'h01);
    stream.push_back(8'h12); stream.push_back(8'h34);
    stream.push_back(8'h56); stream.push_back(8'h78);
    if (CSUM != 0) stream.push_back(8'h01 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
    run_load();
  endtask

  task automatic check_reset_values(input string name);
    check(name, {in_ready, imem_we, imem_addr, imem_wdata, core_reset, core_enable, done, error},
          {1'b0, 1'b0, BASE, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    bp = 1'b0;
    #2 reset = 1'b1;
    #10;
    check_reset_values("reset_values");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("idle_after_reset");

    // directed vector from the program listing
    stream.delete();
    stream.push_back(8'h00); stream.push_back(8'h02);
    stream.push_back(8'h20); stream.push_back(8'h08); stream.push_back(8'h00); stream.push_back(8'h05);
    stream.push_back(8'hAC); stream.push_back(8'h01); stream.push_back(8'h00); stream.push_back(8'h04);
    if (CSUM != 0) stream.push_back(8'h86);
    run_load();
`ifdef SC_LOADER_CHECKSUM_EN
    stream[10] = 8'h87;
    run_load();
`endif

    // oversize, exact maximum and zero length
    make_stream(MAXW + 1, 1'b0);
    run_load();
    make_stream(0, 1'b0);
    run_load();
    bp = 1'b1;
    make_stream(MAXW, 1'b0);
    run_load();

    // random loads, alternating backpressure
    for (int r = 0; r < 8; r++) begin
      bp = r[0];
      make_stream($urandom_range(1, 6), (CSUM != 0) && ($urandom_range(0, 3) == 0));
      run_load();
    end

    // restart after 5 data bytes, and restart in the cycle of a pending write
    bp = 1'b0;
    partial_then_restart(7);
    bp = 1'b1;
    partial_then_restart(7);
    bp = 1'b0;
    partial_then_restart(6);

    // asynchronous reset in the middle of the second word
    make_stream(2, 1'b0);
    predict(8);
    pulse_start(1'b0);
    for (int i = 0; i < 8; i++) send_byte(stream[i]);
    #3 reset = 1'b1;
    #1;
    check_reset_values("async_reset_values");
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check_reset_values("after_async_reset");
    check("reset_writes_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
